// File: rtl/hazard_sched_if.sv
// Hazard scheduler bundle: ID-stage instruction and memory-wait status in,
// forward selects and pipeline hold/bubble controls out.
interface hazard_sched_if;
  logic [15:0] instr_ID;
  logic        valid_ID;
  logic        mem_stall;
  logic [1:0]  ForwardA;
  logic [1:0]  ForwardB;
  logic [1:0]  ForwardS;
  logic        stall_pc;
  logic        stall_ifid;
  logic        bubble_idex;
  logic        halted;

  modport master (
    output instr_ID, valid_ID, mem_stall,
    input  ForwardA, ForwardB, ForwardS, stall_pc, stall_ifid, bubble_idex, halted
  );

  modport slave (
    input  instr_ID, valid_ID, mem_stall,
    output ForwardA, ForwardB, ForwardS, stall_pc, stall_ifid, bubble_idex, halted
  );
endinterface

// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler: tracks EX/MEM destination shadows, produces registered
// forward selects, combinational stall/freeze controls and the HLT drain sequence.
module hazard_sched (
  input logic           clk,
  input logic           rst,
  hazard_sched_if.slave bus
);
  localparam int unsigned REG_W = 4;
  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic             wen;
    logic [REG_W-1:0] rd;
    logic             is_load;
    logic             is_hlt;
  } shadow_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  shadow_t          ex_q, mem_q, dec;
  logic [3:0]       op;
  logic [REG_W-1:0] f_rd, f_rs, f_rt;
  logic [REG_W-1:0] src1, src2, srcs;
  logic             load_use, br_stall, hazard, bubbled, advance;
  logic [1:0]       sel_a, sel_b, sel_s;
  logic             mem_load_unused;

  // Load flag of the MEM shadow is carried for completeness; forwarding from MEM ignores it.
  assign mem_load_unused = mem_q.is_load;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic             ex_wen,
    input logic [REG_W-1:0] ex_rd,
    input logic             ex_load,
    input logic             mem_wen,
    input logic [REG_W-1:0] mem_rd
  );
    if (src == REG_W'(0))                        return 2'b00;
    if (ex_wen && ex_rd == src && !ex_load)      return 2'b10;
    if (mem_wen && mem_rd == src)                return 2'b01;
    return 2'b00;
  endfunction

  // Decode ID: source registers (0 = none) and the shadow record it would create.
  always_comb begin
    op   = bus.instr_ID[15:12];
    f_rd = bus.instr_ID[11:8];
    f_rs = bus.instr_ID[7:4];
    f_rt = bus.instr_ID[3:0];
    src1 = '0;
    src2 = '0;
    srcs = '0;
    dec  = '0;
    if (op <= 4'd9 || op == 4'd13)       src1 = f_rs;
    else if (op == 4'd10 || op == 4'd11) src1 = f_rd;
    if (op <= 4'd3 || op == 4'd7)        src2 = f_rt;
    if (op == 4'd9)                      srcs = f_rd;
    dec.wen     = bus.valid_ID && f_rd != REG_W'(0) &&
                  (op <= 4'd8 || op == 4'd10 || op == 4'd11 || op == 4'd14);
    dec.rd      = f_rd;
    dec.is_load = op == 4'd8;
    dec.is_hlt  = bus.valid_ID && op == 4'd15;
  end

  // Hazard detection and the combinational hold/bubble controls.
  always_comb begin
    load_use = bus.valid_ID && ex_q.is_load && ex_q.wen &&
               (src1 == ex_q.rd || src2 == ex_q.rd || srcs == ex_q.rd);
    br_stall = bus.valid_ID && op == 4'd13 && f_rs != REG_W'(0) &&
               ((ex_q.wen && ex_q.rd == f_rs) || (mem_q.wen && mem_q.rd == f_rs));
    hazard   = load_use || br_stall;
    bubbled  = hazard || state_q != RUN || !bus.valid_ID;
    advance  = !bus.mem_stall;
    sel_a    = fwd_sel(src1, ex_q.wen, ex_q.rd, ex_q.is_load, mem_q.wen, mem_q.rd);
    sel_b    = fwd_sel(src2, ex_q.wen, ex_q.rd, ex_q.is_load, mem_q.wen, mem_q.rd);
    sel_s    = fwd_sel(srcs, ex_q.wen, ex_q.rd, ex_q.is_load, mem_q.wen, mem_q.rd);
    bus.stall_pc    = 1'b0;
    bus.stall_ifid  = 1'b0;
    bus.bubble_idex = 1'b0;
    if (bus.mem_stall) begin
      bus.stall_pc   = 1'b1;
      bus.stall_ifid = 1'b1;
    end else if (state_q != RUN || hazard) begin
      bus.stall_pc    = 1'b1;
      bus.stall_ifid  = 1'b1;
      bus.bubble_idex = 1'b1;
    end
  end

  // Shadows, forward registers and HLT drain FSM; everything holds while frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      ex_q         <= '0;
      mem_q        <= '0;
      bus.ForwardA <= 2'b00;
      bus.ForwardB <= 2'b00;
      bus.ForwardS <= 2'b00;
      bus.halted   <= 1'b0;
    end else if (advance) begin
      mem_q        <= ex_q;
      ex_q         <= bubbled ? shadow_t'(0) : dec;
      bus.ForwardA <= bubbled ? 2'b00 : sel_a;
      bus.ForwardB <= bubbled ? 2'b00 : sel_b;
      bus.ForwardS <= bubbled ? 2'b00 : sel_s;
      case (state_q)
        RUN: begin
          if (!bubbled && dec.is_hlt) begin
            state_q <= DRAIN;
            cnt_q   <= '0;
          end
        end
        DRAIN: begin
          // HLT sitting in MEM now moves to WB.
          if (cnt_q == CNT_W'(1) && mem_q.is_hlt) begin
            state_q    <= HALT;
            bus.halted <= 1'b1;
          end
          cnt_q <= CNT_W'(cnt_q + CNT_W'(1));
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched: directed test-plan scenarios then random traffic,
// compared every cycle against an instruction-level pipeline model.
module tb_hazard_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_sched_if bus();
  hazard_sched dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the instruction words occupying EX and MEM, plus architectural flags.
  logic [15:0] m_ex_w, m_mem_w;
  bit          m_ex_v, m_mem_v;
  logic [1:0]  m_fa, m_fb, m_fs;
  int          m_mode;   // 0 run, 1 drain, 2 halted
  int          m_cnt;
  bit          m_halted;
  bit          e_sp, e_si, e_bub, e_haz;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input int op, input int rd, input int rs, input int rt);
    return {4'(op), 4'(rd), 4'(rs), 4'(rt)};
  endfunction

  function automatic logic [3:0] dest_of(input logic [15:0] w);
    int op = int'(w[15:12]);
    if (op <= 8 || op == 10 || op == 11 || op == 14) return w[11:8];
    return 4'd0;
  endfunction

  function automatic logic [3:0] src1_of(input logic [15:0] w);
    int op = int'(w[15:12]);
    if (op <= 9 || op == 13) return w[7:4];
    if (op == 10 || op == 11) return w[11:8];
    return 4'd0;
  endfunction

  function automatic logic [3:0] src2_of(input logic [15:0] w);
    int op = int'(w[15:12]);
    if (op <= 3 || op == 7) return w[3:0];
    return 4'd0;
  endfunction

  function automatic logic [3:0] srcs_of(input logic [15:0] w);
    if (w[15:12] == 4'd9) return w[11:8];
    return 4'd0;
  endfunction

  function automatic logic [3:0] ex_dest();
    return m_ex_v ? dest_of(m_ex_w) : 4'd0;
  endfunction

  function automatic logic [3:0] mem_dest();
    return m_mem_v ? dest_of(m_mem_w) : 4'd0;
  endfunction

  function automatic bit ex_is_load();
    return m_ex_v && m_ex_w[15:12] == 4'd8;
  endfunction

  function automatic logic [1:0] fsel(input logic [3:0] s);
    if (s == 4'd0) return 2'b00;
    if (ex_dest() == s && !ex_is_load()) return 2'b10;
    if (mem_dest() == s) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_ex_w = '0; m_mem_w = '0; m_ex_v = 0; m_mem_v = 0;
    m_fa = 0; m_fb = 0; m_fs = 0; m_mode = 0; m_cnt = 0; m_halted = 0;
  endtask

  task automatic model_eval(input logic [15:0] w, input bit v, input bit ms);
    logic [3:0] d = ex_dest();
    bit lu, br;
    lu = v && ex_is_load() && d != 0 && (d == src1_of(w) || d == src2_of(w) || d == srcs_of(w));
    br = v && w[15:12] == 4'd13 && w[7:4] != 0 && (d == w[7:4] || mem_dest() == w[7:4]);
    e_haz = lu || br;
    if (ms)                        begin e_sp = 1; e_si = 1; e_bub = 0; end
    else if (m_mode != 0 || e_haz) begin e_sp = 1; e_si = 1; e_bub = 1; end
    else                           begin e_sp = 0; e_si = 0; e_bub = 0; end
  endtask

  task automatic model_clock(input logic [15:0] w, input bit v, input bit ms);
    bit adv;
    logic [1:0] na, nb, ns;
    if (ms) return;
    adv = v && m_mode == 0 && !e_haz;
    na = adv ? fsel(src1_of(w)) : 2'b00;
    nb = adv ? fsel(src2_of(w)) : 2'b00;
    ns = adv ? fsel(srcs_of(w)) : 2'b00;
    m_fa = na; m_fb = nb; m_fs = ns;
    if (m_mode == 1) begin
      m_cnt++;
      if (m_cnt == 2) begin m_mode = 2; m_halted = 1; end
    end
    m_mem_w = m_ex_w; m_mem_v = m_ex_v;
    m_ex_w  = w;      m_ex_v  = adv;
    if (adv && w[15:12] == 4'd15) begin m_mode = 1; m_cnt = 0; end
  endtask

  // One cycle: drive at posedge+1, compare at negedge, advance model, return at next posedge+1.
  task automatic step(input logic [15:0] w, input bit v, input bit ms, input int lit_bub);
    bus.instr_ID = w; bus.valid_ID = v; bus.mem_stall = ms;
    model_eval(w, v, ms);
    #4;
    check("stall_pc",    16'(bus.stall_pc),    16'(e_sp));
    check("stall_ifid",  16'(bus.stall_ifid),  16'(e_si));
    check("bubble_idex", 16'(bus.bubble_idex), 16'(e_bub));
    check("ForwardA",    16'(bus.ForwardA),    16'(m_fa));
    check("ForwardB",    16'(bus.ForwardB),    16'(m_fb));
    check("ForwardS",    16'(bus.ForwardS),    16'(m_fs));
    check("halted",      16'(bus.halted),      16'(m_halted));
    if (lit_bub >= 0) check("bubble_lit", 16'(bus.bubble_idex), 16'(lit_bub));
    model_clock(w, v, ms);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse; the edge after release is frozen so nothing advances.
  task automatic do_reset();
    bus.valid_ID = 0; bus.mem_stall = 0; bus.instr_ID = '0;
    rst = 1'b1;
    #1;
    check("rst_ForwardA", 16'(bus.ForwardA),    16'd0);
    check("rst_ForwardS", 16'(bus.ForwardS),    16'd0);
    check("rst_halted",   16'(bus.halted),      16'd0);
    check("rst_stall_pc", 16'(bus.stall_pc),    16'd0);
    check("rst_bubble",   16'(bus.bubble_idex), 16'd0);
    model_reset();
    bus.mem_stall = 1;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] w;
    bit v, ms, hold;
    int op;
    do_reset();

    // Back-to-back ALU dependency forwards from MEM-stage ALU output.
    step(mk(0, 1, 2, 3), 1, 0, 0);
    step(mk(1, 4, 1, 5), 1, 0, 0);
    check("sub_fwdA", 16'(bus.ForwardA), 16'd2);

    // Store data two behind its producer comes from WriteData.
    step(mk(0, 1, 2, 3), 1, 0, -1);
    step(mk(2, 6, 7, 7), 1, 0, -1);
    step(mk(9, 1, 2, 2), 1, 0, 0);
    check("sw_fwdS", 16'(bus.ForwardS), 16'd1);

    // Load-use: one bubble then WriteData forwarding on both operands.
    step(mk(8, 3, 2, 0), 1, 0, -1);
    step(mk(0, 4, 3, 3), 1, 0, 1);
    step(mk(0, 4, 3, 3), 1, 0, 0);
    check("lu_fwdA", 16'(bus.ForwardA), 16'd1);
    check("lu_fwdB", 16'(bus.ForwardB), 16'd1);

    // Branch on a fresh register stalls two cycles; R0 never forwards.
    step(mk(0, 2, 1, 1), 1, 0, -1);
    step(mk(13, 0, 2, 0), 1, 0, 1);
    step(mk(13, 0, 2, 0), 1, 0, 1);
    step(mk(13, 0, 2, 0), 1, 0, 0);
    step(mk(0, 0, 1, 1), 1, 0, -1);
    step(mk(0, 5, 0, 0), 1, 0, -1);
    check("r0_fwdA", 16'(bus.ForwardA), 16'd0);
    check("r0_fwdB", 16'(bus.ForwardB), 16'd0);

    // Freeze over a load-use: everything holds, bubble still happens afterwards.
    step(16'h0000, 0, 0, -1);
    step(16'h0000, 0, 0, -1);
    step(mk(8, 3, 2, 0), 1, 0, -1);
    for (int i = 0; i < 3; i++) begin
      step(mk(0, 4, 3, 3), 1, 1, 0);
      check("frz_fwdA", 16'(bus.ForwardA), 16'd0);
    end
    step(mk(0, 4, 3, 3), 1, 0, 1);
    step(mk(0, 4, 3, 3), 1, 0, 0);
    check("frz_lu_fwdA", 16'(bus.ForwardA), 16'd1);

    // HLT drain with a two-cycle freeze in the middle.
    step(16'h0000, 0, 0, -1);
    step(16'h0000, 0, 0, -1);
    step(mk(15, 0, 0, 0), 1, 0, 0);
    step(mk(15, 0, 0, 0), 1, 0, 1);
    step(mk(15, 0, 0, 0), 1, 1, 0);
    step(mk(15, 0, 0, 0), 1, 1, 0);
    check("hlt_not_yet", 16'(bus.halted), 16'd0);
    step(mk(15, 0, 0, 0), 1, 0, 1);
    check("hlt_halted", 16'(bus.halted), 16'd1);
    step(mk(15, 0, 0, 0), 1, 0, 1);
    do_reset();

    // Random traffic on a small register set to make hazards frequent.
    hold = 0;
    w = '0;
    v = 0;
    for (int i = 0; i < 1500; i++) begin
      if ((m_mode == 2 && $urandom_range(0, 5) == 0) || $urandom_range(0, 199) == 0) begin
        do_reset();
        hold = 0;
        continue;
      end
      if (!hold) begin
        op = int'($urandom_range(0, 15));
        if (op == 15 && $urandom_range(0, 3) != 0) op = int'($urandom_range(0, 14));
        w = mk(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        v = $urandom_range(0, 9) != 0;
      end
      ms = $urandom_range(0, 6) == 0;
      step(w, v, ms, -1);
      hold = e_si;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
